// File: rtl/uart_mem_xfer.sv
// UART-to-RAM transfer engine: loads little-endian words from an 8N1 serial stream into one of
// NUM_RAMS RAMs, or dumps RAM words out over serial. Optional timeout: UART_MEM_XFER_TIMEOUT_EN.
module uart_mem_xfer #(
  parameter int unsigned CLKS_PER_BIT   = 10417,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned NUM_RAMS       = 2,
  parameter int unsigned ADDR_BIT       = 8,
  parameter int unsigned TIMEOUT_BYTES  = 4,
  localparam int unsigned DATA_W = 8 * BYTES_PER_WORD,
  localparam int unsigned SEL_W  = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [SEL_W-1:0]    ram_sel,
  input  logic [ADDR_BIT:0]   xfer_len,
  input  logic                uart_rx,
  output logic                uart_tx,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [NUM_RAMS-1:0] mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned BI_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BitEnd  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfBit = CNT_W'((CLKS_PER_BIT - 1) / 2);

  // Receiver: bit 0 is the start bit (checked mid-bit), 1..8 data LSB first, 9 the stop bit.
  logic [1:0]       rx_sync_q;
  logic             rx_act_q, rx_dv_q, rx_in;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [3:0]       rx_bit_q;
  logic [7:0]       rx_byte_q;

  assign rx_in = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_act_q  <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_byte_q <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_dv_q   <= 1'b0;
      if (!rx_act_q) begin
        rx_cnt_q <= '0;
        rx_bit_q <= '0;
        rx_act_q <= !rx_in;
      end else if ((rx_bit_q == 4'd0) ? (rx_cnt_q == HalfBit) : (rx_cnt_q == BitEnd)) begin
        rx_cnt_q <= '0;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          rx_act_q <= !rx_in;  // glitch: line already back high
        end else if (rx_bit_q == 4'd9) begin
          rx_act_q <= 1'b0;
          rx_dv_q  <= rx_in;   // framing error drops the byte
        end else begin
          rx_byte_q <= {rx_in, rx_byte_q[7:1]};
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      end
    end
  end

  // Transmitter
  logic             tx_dv, tx_act_q, tx_done_q;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;
  logic [9:0]       tx_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_act_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_act_q) begin
        if (tx_dv) begin
          tx_act_q   <= 1'b1;
          tx_shift_q <= {1'b1, tx_byte, 1'b0};
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
        end
      end else if (tx_cnt_q == BitEnd) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) begin
          tx_act_q  <= 1'b0;
          tx_done_q <= 1'b1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
    end
  end

  assign uart_tx = !tx_act_q | tx_shift_q[0];

  // Transfer sequencer
  typedef enum logic [2:0] {
    StIdle, StRxCollect, StRxWrite, StTxFetch, StTxLoad, StTxSend, StTxWait, StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_BIT:0]   len_q, len_d;
  logic [ADDR_BIT-1:0] word_idx_q, word_idx_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                err_q, err_d;
  logic                last_word, last_byte, timeout;

  // len_q is one bit wider than the index, so len = 2^ADDR_BIT ends at the top address.
  assign last_word = ({1'b0, word_idx_q} + (ADDR_BIT + 1)'(1)) == len_q;
  assign last_byte = byte_idx_q == BI_W'(BYTES_PER_WORD - 1);

`ifdef UART_MEM_XFER_TIMEOUT_EN
  localparam int unsigned ToLim = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int unsigned TO_W  = $clog2(ToLim + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != StRxCollect || byte_idx_q == '0 || rx_dv_q || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = to_cnt_q == TO_W'(ToLim - 1);
`else
  // Partial words wait indefinitely; TIMEOUT_BYTES only matters when the timeout is built.
  assign timeout = (TIMEOUT_BYTES == 0) && 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    err_d      = err_q;
    tx_dv      = 1'b0;
    tx_byte    = word_q[{byte_idx_q, 3'b000} +: 8];
    mem_we     = '0;
    unique case (state_q)
      StIdle: if (start) begin
        sel_d      = ram_sel;
        len_d      = (xfer_len == '0) ? {1'b1, {ADDR_BIT{1'b0}}} : xfer_len;
        err_d      = 1'b0;
        word_idx_d = '0;
        byte_idx_d = '0;
        if ({1'b0, ram_sel} >= (SEL_W + 1)'(NUM_RAMS)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = mode ? StTxFetch : StRxCollect;
        end
      end
      StRxCollect: begin
        if (timeout) begin
          byte_idx_d = '0;
          err_d      = 1'b1;
        end else if (rx_dv_q) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte_q;
          if (last_byte) begin
            byte_idx_d = '0;
            state_d    = StRxWrite;
          end else begin
            byte_idx_d = byte_idx_q + BI_W'(1);
          end
        end
      end
      StRxWrite: begin
        mem_we[sel_q] = 1'b1;
        if (rx_dv_q) begin
          word_d[7:0] = rx_byte_q;
          if (BYTES_PER_WORD > 1) byte_idx_d = BI_W'(1);
        end
        if (last_word) begin
          state_d = StFinish;
        end else begin
          word_idx_d = word_idx_q + ADDR_BIT'(1);
          state_d    = StRxCollect;
        end
      end
      StTxFetch: state_d = StTxLoad;
      StTxLoad: begin
        word_d     = mem_rdata;
        byte_idx_d = '0;
        state_d    = StTxSend;
      end
      StTxSend: begin
        tx_dv   = 1'b1;
        state_d = StTxWait;
      end
      StTxWait: if (tx_done_q) begin
        if (!last_byte) begin
          byte_idx_d = byte_idx_q + BI_W'(1);
          state_d    = StTxSend;
        end else if (last_word) begin
          byte_idx_d = '0;
          state_d    = StFinish;
        end else begin
          byte_idx_d = '0;
          word_idx_d = word_idx_q + ADDR_BIT'(1);
          state_d    = StTxFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_addr  = word_idx_q;
  assign mem_wdata = word_q;
  assign busy      = (state_q != StIdle) && (state_q != StFinish);
  assign done      = state_q == StFinish;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_mem_xfer.sv
// Self-checking bench for uart_mem_xfer: serial driver/monitor, RAM store and word/byte model.
module tb_uart_mem_xfer;
  localparam int CPB   = 8;
  localparam int BPW   = 4;
  localparam int NR    = 3;
  localparam int AB    = 3;
  localparam int DW    = 8 * BPW;
  localparam int SW    = 2;
  localparam int DEPTH = 1 << AB;

  typedef logic [7:0]    bq_t[$];
  typedef logic [DW-1:0] wq_t[$];
  typedef struct {int r; int a; logic [DW-1:0] d;} wr_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, uart_rx = 1'b1;
  logic [SW-1:0] ram_sel = '0;
  logic [AB:0]   xfer_len = '0;
  logic          uart_tx, busy, done, err;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [NR-1:0] mem_we;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_mem_xfer #(
    .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .NUM_RAMS(NR), .ADDR_BIT(AB), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ram_sel(ram_sel),
    .xfer_len(xfer_len), .uart_rx(uart_rx), .uart_tx(uart_tx), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .err(err)
  );

  // RAM store with registered read; preloads come through the same process.
  logic [DW-1:0] ram [NR][DEPTH];
  logic [DW-1:0] exp_mem [NR][DEPTH];
  int            rd_sel = 0;
  logic          pre_we = 1'b0;
  int            pre_r = 0, pre_a = 0;
  logic [DW-1:0] pre_d = '0;
  wr_t           wr_q[$];
  wr_t           mon_e;
  int            done_cnt = 0;

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) if (mem_we[r]) ram[r][mem_addr] <= mem_wdata;
    if (pre_we) ram[pre_r][pre_a] <= pre_d;
    mem_rdata <= ram[rd_sel][mem_addr];
    if (done) done_cnt <= done_cnt + 1;
    for (int r = 0; r < NR; r++) if (mem_we[r]) begin
      mon_e.r = r;
      mon_e.a = int'(mem_addr);
      mon_e.d = mem_wdata;
      wr_q.push_back(mon_e);
    end
  end

  // Serial monitor on uart_tx
  logic [7:0] tx_q[$];
  logic [7:0] mon_b;
  initial forever begin
    @(negedge uart_tx);
    if (rst_n) begin
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      tx_q.push_back(mon_b);
    end
  end

  function automatic wq_t pack_words(input bq_t b);
    wq_t w;
    logic [DW-1:0] x;
    for (int k = 0; k < b.size() / BPW; k++) begin
      x = '0;
      for (int j = 0; j < BPW; j++) x = x | (DW'(b[k * BPW + j]) << (8 * j));
      w.push_back(x);
    end
    return w;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t b;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_bytes(input bq_t b);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic do_start(input logic m, input logic [SW-1:0] s, input logic [AB:0] l);
    @(negedge clk);
    mode = m; ram_sel = s; xfer_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic preload(input int r, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_r = r; pre_a = a; pre_d = d;
    exp_mem[r][a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 000", busy, done, err);
    end
    total++; if (mem_we !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h want 0", mem_we, mem_addr, mem_wdata);
    end
  endtask

  // Writes captured since wr_q was cleared must match the model words at addresses 0..n-1.
  task automatic check_writes(input string name, input int sel, input wq_t exp);
    total++;
    if (wr_q.size() != exp.size()) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", name, wr_q.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < wr_q.size(); k++) begin
      total++;
      if (wr_q[k].r != sel || wr_q[k].a != k || wr_q[k].d !== exp[k]) begin
        bad++; $display("FAIL %s_w%0d: got ram%0d[%0d]=%h want ram%0d[%0d]=%h", name, k,
                        wr_q[k].r, wr_q[k].a, wr_q[k].d, sel, k, exp[k]);
      end
    end
  endtask

  task automatic run_load(input string name, input int sel, input logic [AB:0] l, input bq_t b);
    bit ok;
    int prev;
    wr_q.delete();
    prev = done_cnt;
    do_start(1'b0, SW'(sel), l);
    total++; if (busy !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL %s_start: got busy=%b err=%b want busy=1 err=0", name, busy, err);
    end
    send_bytes(b);
    wait_done(prev, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_done: got no done want done pulse", name); end
    for (int k = 0; k < b.size() / BPW; k++) exp_mem[sel][k] = pack_words(b)[k];
    check_writes(name, sel, pack_words(b));
  endtask

  task automatic test_load;
    bq_t b;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("load", 1, 4'd2, b);
    total++; if (pack_words(b)[1] !== 32'h88776655 || err !== 1'b0) begin
      bad++; $display("FAIL load_err: got err=%b want 0", err);
    end
  endtask

  task automatic run_dump(input string name, input int sel, input int n);
    bit ok;
    int prev;
    bq_t exp;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < BPW; j++) exp.push_back(8'(exp_mem[sel][k] >> (8 * j)));
    rd_sel = sel;
    tx_q.delete();
    prev = done_cnt;
    do_start(1'b1, SW'(sel), (AB + 1)'(n));
    wait_done(prev, n * BPW * 100 + 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_done: got no done want done pulse", name); end
    total++; if (tx_q.size() != exp.size()) begin
      bad++; $display("FAIL %s_count: got %0d bytes want %0d", name, tx_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
      total++; if (tx_q[i] !== exp[i]) begin
        bad++; $display("FAIL %s_b%0d: got %h want %h", name, i, tx_q[i], exp[i]);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b want 0", name, busy); end
  endtask

  task automatic test_dump;
    preload(0, 0, 32'hDEADBEEF);
    run_dump("dump", 0, 1);
  endtask

  task automatic test_full_len;
    run_load("full", 0, '0, rand_bytes(DEPTH * BPW));
  endtask

  task automatic test_bad_sel;
    bit ok;
    int prev;
    wr_q.delete();
    prev = done_cnt;
    do_start(1'b0, 2'd3, 4'd1);
    wait_done(prev, 3, ok);
    total++; if (!ok || err !== 1'b1) begin
      bad++; $display("FAIL bad_sel: got done=%b err=%b want done=1 err=1", ok, err);
    end
    total++; if (wr_q.size() != 0) begin
      bad++; $display("FAIL bad_sel_we: got %0d writes want 0", wr_q.size());
    end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    int prev;
    bq_t b;
    b = rand_bytes(BPW);
    wr_q.delete();
    tx_q.delete();
    prev = done_cnt;
    do_start(1'b0, 2'd1, 4'd1);
    send_byte(b[0]);
    send_byte(b[1]);
    do_start(1'b1, 2'd0, 4'd5);
    send_byte(b[2]);
    send_byte(b[3]);
    wait_done(prev, 60, ok);
    repeat (100) @(negedge clk);
    total++; if (!ok || done_cnt != prev + 1 || tx_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore: got dones=%0d tx=%0d busy=%b want 1 0 0",
                      done_cnt - prev, tx_q.size(), busy);
    end
    exp_mem[1][0] = pack_words(b)[0];
    check_writes("busy_ignore", 1, pack_words(b));
  endtask

  task automatic test_random;
    int sel, n;
    for (int it = 0; it < 3; it++) begin
      sel = $urandom_range(0, NR - 1);
      n = $urandom_range(1, DEPTH);
      run_load("rnd_load", sel, (AB + 1)'(n), rand_bytes(n * BPW));
      sel = $urandom_range(0, NR - 1);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) preload(sel, k, DW'($urandom));
      run_dump("rnd_dump", sel, n);
    end
  endtask

  task automatic test_reset_abort;
    wr_q.delete();
    do_start(1'b0, 2'd1, 4'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || uart_tx !== 1'b1 || mem_we !== '0) begin
      bad++; $display("FAIL abort_load: got busy=%b tx=%b we=%b want 0 1 0", busy, uart_tx, mem_we);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    preload(0, 0, 32'h0000_0000);
    do_start(1'b1, 2'd0, 4'd1);
    repeat (6) @(negedge clk);
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL abort_dump_low: got %b want 0", uart_tx); end
    rst_n = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_dump: got tx=%b busy=%b want 1 0", uart_tx, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    tx_q.delete();
    total++; if (wr_q.size() != 0) begin
      bad++; $display("FAIL abort_we: got %0d writes want 0", wr_q.size());
    end
    run_load("after_abort", 1, 4'd1, rand_bytes(BPW));
  endtask

`ifdef UART_MEM_XFER_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int prev;
    wq_t exp;
    wr_q.delete();
    prev = done_cnt;
    do_start(1'b0, 2'd1, 4'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (4 * 10 * CPB + 80) @(negedge clk);
    send_bytes('{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    wait_done(prev, 60, ok);
    total++; if (!ok || err !== 1'b1) begin
      bad++; $display("FAIL timeout: got done=%b err=%b want 1 1", ok, err);
    end
    exp.push_back(32'hDDCCBBAA);
    check_writes("timeout", 1, exp);
  endtask
`endif

  initial begin
    repeat (4) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_load;
    test_dump;
    test_full_len;
    test_bad_sel;
    test_busy_ignore;
    test_random;
    test_reset_abort;
`ifdef UART_MEM_XFER_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
